// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl : direct-mapped, write-through, no-write-allocate data cache
//               controller with one 32-bit word per line.
//
// Ports
//   clk, nrst                 clock, asynchronous active-low reset
//   core_req/core_we/core_addr/core_wdata   core request (held until ready)
//   core_rdata, core_ready    load data / request-complete strobe
//   flush                     invalidate every line
//   mem_en/mem_we/mem_addr/mem_din  backing RAM port (word addressed)
//   mem_dout                  RAM read data, one cycle after a read enable
//   hit_count, miss_count     saturating load hit / miss counters
// ---------------------------------------------------------------------------
module dcache_ctrl #(
   parameter int ADDR_WIDTH = 11,
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  core_req,
   input  logic [3:0]            core_we,
   input  logic [31:0]           core_addr,
   input  logic [31:0]           core_wdata,
   output logic [31:0]           core_rdata,
   output logic                  core_ready,
   input  logic                  flush,
   output logic                  mem_en,
   output logic [3:0]            mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

   typedef enum logic [0:0] {
      ST_IDLE      = 1'b0,
      ST_MISS_WAIT = 1'b1
   } state_e;

   // Byte-lane merge of store data into an existing line word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return res;
   endfunction

   state_e                state_q, state_d;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [31:0]           data_q [LINES];
   logic [31:0]           hit_count_q, miss_count_q;

   logic [ADDR_WIDTH-1:0] word_addr_s;
   logic [INDEX_BITS-1:0] index_s;
   logic [TAG_BITS-1:0]   tag_s;
   logic                  is_load_s, hit_s;
   logic                  hit_inc_s, miss_inc_s, fill_s, store_hit_s, flush_s;
   logic                  unused_addr_s;

   assign word_addr_s   = core_addr[ADDR_WIDTH+1:2];
   assign index_s       = word_addr_s[INDEX_BITS-1:0];
   assign tag_s         = word_addr_s[ADDR_WIDTH-1:INDEX_BITS];
   assign is_load_s     = (core_we == 4'b0000);
   assign hit_s         = valid_q[index_s] && (tag_q[index_s] == tag_s);
   assign unused_addr_s = ^{core_addr[31:ADDR_WIDTH+2], core_addr[1:0]};

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // Next-state and combinational outputs; everything is gated off while
   // nrst is low so the RAM port and core handshake are quiet in reset.
   always_comb begin
      state_d     = state_q;
      core_ready  = 1'b0;
      core_rdata  = data_q[index_s];
      mem_en      = 1'b0;
      mem_we      = 4'b0000;
      mem_addr    = word_addr_s;
      mem_din     = core_wdata;
      hit_inc_s   = 1'b0;
      miss_inc_s  = 1'b0;
      fill_s      = 1'b0;
      store_hit_s = 1'b0;
      flush_s     = 1'b0;
      if (!nrst) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  // Flush has priority: the request waits for the next cycle.
                  flush_s = 1'b1;
               end else if (core_req) begin
                  if (!is_load_s) begin
                     mem_en      = 1'b1;
                     mem_we      = core_we;
                     core_ready  = 1'b1;
                     store_hit_s = hit_s;
                  end else if (hit_s) begin
                     core_ready = 1'b1;
                     hit_inc_s  = 1'b1;
                  end else begin
                     mem_en     = 1'b1;
                     miss_inc_s = 1'b1;
                     state_d    = ST_MISS_WAIT;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MISS_WAIT: begin
               // Request fields are still held, so index/tag remain valid here.
               core_ready = 1'b1;
               core_rdata = mem_dout;
               fill_s     = 1'b1;
               flush_s    = flush;
               state_d    = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, valid bits and counters (reset-cleared).
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         valid_q      <= '0;
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         // A flush during the fill wins, so the filled line ends invalid.
         if (flush_s) begin
            valid_q <= '0;
         end else if (fill_s) begin
            valid_q[index_s] <= 1'b1;
         end else begin
            valid_q <= valid_q;
         end
         if (hit_inc_s && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_q <= hit_count_q + 32'd1;
         end else begin
            hit_count_q <= hit_count_q;
         end
         if (miss_inc_s && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_q <= miss_count_q + 32'd1;
         end else begin
            miss_count_q <= miss_count_q;
         end
      end
   end

   // Line tags and data; intentionally not reset, validity lives in valid_q.
   always_ff @(posedge clk) begin
      if (fill_s) begin
         tag_q[index_s]  <= tag_s;
         data_q[index_s] <= mem_dout;
      end else if (store_hit_s) begin
         data_q[index_s] <= merge_bytes(data_q[index_s], core_wdata, core_we);
      end else begin
         data_q[index_s] <= data_q[index_s];
      end
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 11, word-address width of the backing data RAM port.
REQ-002 Parameter: INDEX_BITS, 4, cache index width; line count = 2**INDEX_BITS, one 32-bit word per line.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 nrst  in  1  asynchronous reset, active low.
REQ-005 core_req  in  1  core load/store request; held stable with all request fields until core_ready=1.
REQ-006 core_we  in  4  byte write enables; 4'b0000 selects a load.
REQ-007 core_addr  in  32  byte address; bits [ADDR_WIDTH+1:2] form the word address; all other bits are ignored.
REQ-008 core_wdata  in  32  store data, byte lanes aligned to core_we.
REQ-009 core_rdata  out  32  load data, valid when core_ready=1 on a load.
REQ-010 core_ready  out  1  request completes in this cycle.
REQ-011 flush  in  1  invalidate all lines.
REQ-012 mem_en  out  1  RAM port enable.
REQ-013 mem_we  out  4  RAM byte write enables.
REQ-014 mem_addr  out  ADDR_WIDTH  RAM word address.
REQ-015 mem_din  out  32  RAM write data.
REQ-016 mem_dout  in  32  RAM read data, registered, valid the cycle after mem_en=1 with mem_we=0.
REQ-017 hit_count  out  32  load hits, saturating.
REQ-018 miss_count  out  32  load misses, saturating.

Function
REQ-019 Organisation: direct-mapped, write-through, no-write-allocate; index = word_addr[INDEX_BITS-1:0]; tag = word_addr[ADDR_WIDTH-1:INDEX_BITS]; per line: valid bit, tag, 32-bit data, all held in flops.
REQ-020 FSM: IDLE and MISS_WAIT only.
REQ-021 IDLE, flush=1: all valid bits clear at the edge; core_ready=0; no request accepted; mem_en=0.
REQ-022 IDLE, core_req=1, load hit (valid and tag match): core_ready=1 and core_rdata=line data in the same cycle (combinational); mem_en=0; hit_count increments.
REQ-023 IDLE, load miss: mem_en=1, mem_we=0, mem_addr=word address; core_ready=0; miss_count increments; next state MISS_WAIT.
REQ-024 MISS_WAIT: core_rdata=mem_dout; core_ready=1; line is written with mem_dout, tag and valid=1; next state IDLE; mem_en=0.
REQ-025 MISS_WAIT with flush=1: fill data is still returned to the core; the line's valid bit ends 0; all other valid bits clear.
REQ-026 IDLE, store (core_we!=0): mem_en=1, mem_we=core_we, mem_addr=word address, mem_din=core_wdata; core_ready=1 in the same cycle; store takes 1 cycle.
REQ-027 Store hit: enabled byte lanes are merged into line data at the edge; tag and valid are unchanged.
REQ-028 Store miss: the cache is unchanged; the store is not counted.
REQ-029 Idle cycles (core_req=0, flush=0): mem_en=0, mem_we=0, core_ready=0.
REQ-030 Counters: each counter holds at 32'hFFFFFFFF.
REQ-031 A load to an address stored in the previous cycle returns the merged data.

Reset
REQ-032 nrst=0 forces, asynchronously: state IDLE, all valid bits 0, hit_count=0, miss_count=0, core_ready=0, mem_en=0, mem_we=0.
REQ-033 Reset does not clear line data or tags.
REQ-034 Reset during MISS_WAIT abandons the fill; the core reissues the request after reset.

Verification
REQ-035 Cold load: RAM word 0x005=0xA5A5A5A5, load addr 0x14 -> cycle 0: mem_en=1, mem_addr=0x005, core_ready=0; cycle 1: core_ready=1, core_rdata=0xA5A5A5A5; miss_count=1.
REQ-036 Repeat the load -> core_ready=1 in the same cycle, mem_en=0, rdata=0xA5A5A5A5, hit_count=1.
REQ-037 Store hit: store we=4'b0011, data=0x00001234 to 0x14 -> mem_we=0011 and mem_din=0x00001234 in one cycle; the next load hits and returns 0xA5A51234.
REQ-038 Conflict: load 0x14, then load 0x54 (same index, different tag) -> second load misses; a third load of 0x14 misses again; miss_count=3.
REQ-039 Flush: flush=1 in IDLE, then load 0x14 -> miss, mem_en=1; flush asserted during MISS_WAIT -> data returned, next identical load misses.
REQ-040 Reset mid-miss: nrst=0 in MISS_WAIT -> core_ready=0, mem_en=0, counters=0 immediately; after release, the reissued load misses.
